// File: rtl/dcache_ctrl_if.sv
// Request-side and memory-side signal bundle for dcache_ctrl.
// The slave modport is the cache view; master is the pipeline/memory environment view.
interface dcache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, Stall, CacheHit, err,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, Stall, CacheHit, err,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with single-word miss port.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_ctrl #(
  parameter int INDEX_BITS     = 5,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 13 - INDEX_BITS;
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_LINE - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WB      = 2'd1;
  localparam logic [1:0] ALLOC   = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]            state;
  logic [1:0]            cnt;
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [15:0]           data_mem [LINES][4];

  // Line identity captured at miss detection; the refill never looks at Addr again
  logic [TAG_W-1:0]      vtag_r;
  logic [TAG_W-1:0]      rtag_r;
  logic [INDEX_BITS-1:0] idx_r;

  logic [TAG_W-1:0]      tag_in;
  logic [INDEX_BITS-1:0] idx_in;
  logic [1:0]            word_in;
  logic                  req_ok, hit_in, idle_hit, idle_miss, resp_done, last_ack;
  logic [15:0]           rd_word;

  assign tag_in    = bus.Addr[15 -: TAG_W];
  assign idx_in    = bus.Addr[2+INDEX_BITS:3];
  assign word_in   = bus.Addr[2:1];
  assign bus.err   = (bus.Rd && bus.Wr) || ((bus.Rd || bus.Wr) && bus.Addr[0]);
  assign req_ok    = (bus.Rd || bus.Wr) && !bus.err;
  assign hit_in    = valid[idx_in] && (tag_mem[idx_in] == tag_in);
  assign idle_hit  = (state == IDLE) && req_ok && hit_in;
  assign idle_miss = (state == IDLE) && req_ok && !hit_in;
  assign resp_done = (state == RESPOND) && req_ok;
  assign last_ack  = bus.mem_ack && (cnt == LAST_WORD);
  assign rd_word   = (state == RESPOND) ? data_mem[idx_r][word_in] : data_mem[idx_in][word_in];

  always_comb begin
    bus.Done      = idle_hit || resp_done;
    bus.CacheHit  = idle_hit;
    bus.Stall     = idle_miss || (state == WB) || (state == ALLOC);
    bus.DataOut   = (bus.Done && bus.Rd) ? rd_word : 16'h0000;
    bus.mem_req   = (state == WB) || (state == ALLOC);
    bus.mem_we    = (state == WB);
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    if (state == WB) begin
      bus.mem_addr  = {vtag_r, idx_r, cnt, 1'b0};
      bus.mem_wdata = data_mem[idx_r][cnt];
    end else if (state == ALLOC) begin
      bus.mem_addr  = {rtag_r, idx_r, cnt, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit && bus.Wr) begin
            dirty[idx_in] <= 1'b1;
          end else if (idle_miss) begin
            state <= (valid[idx_in] && dirty[idx_in]) ? WB : ALLOC;
            cnt   <= 2'd0;
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            cnt <= last_ack ? 2'd0 : cnt + 2'd1;
            if (last_ack) state <= ALLOC;
          end
        end
        ALLOC: begin
          if (bus.mem_ack) begin
            cnt <= last_ack ? 2'd0 : cnt + 2'd1;
            if (last_ack) begin
              valid[idx_r] <= 1'b1;
              dirty[idx_r] <= 1'b0;
              state        <= RESPOND;
            end
          end
        end
        default: begin
          if (resp_done && bus.Wr) dirty[idx_r] <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage arrays carry no reset; validity is governed solely by valid[]
  always_ff @(posedge clk) begin
    if (idle_miss) begin
      vtag_r <= tag_mem[idx_in];
      rtag_r <= tag_in;
      idx_r  <= idx_in;
    end
    if (idle_hit && bus.Wr) data_mem[idx_in][word_in] <= bus.DataIn;
    if ((state == ALLOC) && bus.mem_ack) begin
      data_mem[idx_r][cnt] <= bus.mem_rdata;
      if (last_ack) tag_mem[idx_r] <= rtag_r;
    end
    if (resp_done && bus.Wr) data_mem[idx_r][word_in] <= bus.DataIn;
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (idle_hit)  hit_cnt  <= sat_inc(hit_cnt);
      if (resp_done) miss_cnt <= sat_inc(miss_cnt);
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`else
  assign bus.hit_count  = 16'h0000;
  assign bus.miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();
  dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } op_t;

  // Reference state: main memory by word, and one entry per cache line
  logic [15:0] mem_m [32768];
  logic [7:0]  m_tag [32];
  bit          m_valid [32];
  bit          m_dirty [32];
  logic [15:0] m_data [32][4];
  int          exp_hits, exp_miss;

  int          n_cmp, n_bad;
  int          last_k;
  logic [15:0] last_dout;
  logic        last_hit;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters();
`ifdef DCACHE_STATS_EN
    check("hit_count", bus.hit_count, 16'(exp_hits));
    check("miss_count", bus.miss_count, 16'(exp_miss));
`else
    check("hit_count", bus.hit_count, 16'h0000);
    check("miss_count", bus.miss_count, 16'h0000);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [15:0] d, input int lat);
    logic [7:0]  tg;
    logic [4:0]  ix;
    logic [1:0]  w;
    bit          hit, finished, ack_now;
    int          k, waited;
    op_t         op;
    op_t         ops[$];
    tg = a[15:8];
    ix = a[7:3];
    w  = a[2:1];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    if (!hit) begin
      if (m_valid[ix] && m_dirty[ix])
        for (int i = 0; i < 4; i++) begin
          op.addr = {m_tag[ix], ix, 2'(i), 1'b0}; op.we = 1'b1; op.wdata = m_data[ix][i];
          ops.push_back(op);
        end
      for (int i = 0; i < 4; i++) begin
        op.addr = {tg, ix, 2'(i), 1'b0}; op.we = 1'b0; op.wdata = 16'h0000;
        ops.push_back(op);
      end
    end
    @(negedge clk);
    check_counters();
    bus.Addr = a; bus.Rd = rd; bus.Wr = wr; bus.DataIn = d;
    k = 0; waited = 0; finished = 0; ack_now = 0;
    while (!finished && k < 200) begin
      #1;
      check("err", bus.err, 16'h0000);
      if (k == 0 && !hit) begin
        check("miss_done", bus.Done, 16'h0000);
        check("miss_stall", bus.Stall, 16'h0001);
        check("miss_mem_req", bus.mem_req, 16'h0000);
      end else if (ops.size() > 0) begin
        check("fill_done", bus.Done, 16'h0000);
        check("fill_stall", bus.Stall, 16'h0001);
        check("mem_req", bus.mem_req, 16'h0001);
        check("mem_we", bus.mem_we, 16'(ops[0].we));
        check("mem_addr", bus.mem_addr, ops[0].addr);
        if (ops[0].we) check("mem_wdata", bus.mem_wdata, ops[0].wdata);
        if (waited >= lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem_m[ops[0].addr[15:1]];
          ack_now = 1;
        end else begin
          waited++;
        end
      end else begin
        if (!hit) begin
          m_tag[ix] = tg; m_valid[ix] = 1; m_dirty[ix] = 0;
        end
        check("done", bus.Done, 16'h0001);
        check("stall", bus.Stall, 16'h0000);
        check("cache_hit", bus.CacheHit, 16'(hit));
        check("done_mem_req", bus.mem_req, 16'h0000);
        check("data_out", bus.DataOut, rd ? m_data[ix][w] : 16'h0000);
        last_dout = bus.DataOut; last_hit = bus.CacheHit; last_k = k;
        if (wr) begin
          m_data[ix][w] = d;
          m_dirty[ix] = 1;
        end
        if (hit) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : exp_hits;
        else     exp_miss = (exp_miss < 65535) ? exp_miss + 1 : exp_miss;
        finished = 1;
      end
      @(posedge clk);
      if (ack_now) begin
        if (ops[0].we) mem_m[ops[0].addr[15:1]] = ops[0].wdata;
        else           m_data[ix][ops[0].addr[2:1]] = mem_m[ops[0].addr[15:1]];
        void'(ops.pop_front());
        waited = 0;
        ack_now = 0;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (finished) begin
        bus.Rd = 1'b0; bus.Wr = 1'b0;
      end
      k++;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no Done for addr %h after %0d cycles", a, k);
      bus.Rd = 1'b0; bus.Wr = 1'b0;
    end
  endtask

  task automatic err_access(input logic [15:0] a, input logic rd, input logic wr);
    @(negedge clk);
    bus.Addr = a; bus.Rd = rd; bus.Wr = wr; bus.DataIn = 16'hDEAD;
    #1;
    check("err_flag", bus.err, 16'h0001);
    check("err_done", bus.Done, 16'h0000);
    check("err_stall", bus.Stall, 16'h0000);
    check("err_mem_req", bus.mem_req, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    bus.Rd = 1'b0; bus.Wr = 1'b0;
    #1;
    check("err_clear", bus.err, 16'h0000);
  endtask

  initial begin
    logic [7:0] tg_tab [4];
    logic [7:0] tg;
    logic [4:0] ix;
    logic [1:0] w;
    int         sel;
    tg_tab[0] = 8'h00; tg_tab[1] = 8'h10; tg_tab[2] = 8'h20; tg_tab[3] = 8'h31;
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 32768; i++) mem_m[i] = 16'(i) ^ 16'h3C5A;
    mem_m[8] = 16'h00A0; mem_m[9] = 16'h00A1; mem_m[10] = 16'h00A2; mem_m[11] = 16'h00A3;
    for (int i = 0; i < 32; i++) m_tag[i] = 8'h00;
    model_reset();
    bus.Addr = 16'h0000; bus.DataIn = 16'h0000; bus.Rd = 1'b0; bus.Wr = 1'b0;
    bus.mem_rdata = 16'h0000; bus.mem_ack = 1'b0;

    #1;
    check("rst_done", bus.Done, 16'h0000);
    check("rst_stall", bus.Stall, 16'h0000);
    check("rst_hit", bus.CacheHit, 16'h0000);
    check("rst_err", bus.err, 16'h0000);
    check("rst_mem_req", bus.mem_req, 16'h0000);
    check("rst_mem_we", bus.mem_we, 16'h0000);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    check("rst_dout", bus.DataOut, 16'h0000);
    check_counters();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    access(16'h0010, 1'b1, 1'b0, 16'h0000, 0);
    check("cold_cycles", 16'(last_k), 16'd5);
    check("cold_dout", last_dout, 16'h00A0);
    check("cold_hit", 16'(last_hit), 16'h0000);
    access(16'h0014, 1'b1, 1'b0, 16'h0000, 0);
    check("hit_cycles", 16'(last_k), 16'd0);
    check("hit_dout", last_dout, 16'h00A2);
    check("hit_flag", 16'(last_hit), 16'h0001);
    access(16'h0012, 1'b0, 1'b1, 16'hBEEF, 0);
    check("wr_hit_flag", 16'(last_hit), 16'h0001);
    access(16'h1010, 1'b1, 1'b0, 16'h0000, 0);
    check("evict_cycles", 16'(last_k), 16'd9);
    check("evict_wb_w0", mem_m[8], 16'h00A0);
    check("evict_wb_w1", mem_m[9], 16'hBEEF);
    check("evict_wb_w3", mem_m[11], 16'h00A3);
    access(16'h2010, 1'b1, 1'b0, 16'h0000, 3);
    check("slow_cycles", 16'(last_k), 16'd17);

    err_access(16'h0014, 1'b1, 1'b1);
    err_access(16'h0011, 1'b1, 1'b0);
    err_access(16'h0013, 1'b0, 1'b1);
    access(16'h2014, 1'b1, 1'b0, 16'h0000, 0);
    check("after_err_hit", 16'(last_hit), 16'h0001);

    // Abandon a refill after two words, then confirm the line is gone
    @(negedge clk);
    bus.Addr = 16'h0050; bus.Rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k > 0) begin
        check("abort_mem_req", bus.mem_req, 16'h0001);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem_m[bus.mem_addr[15:1]];
      end
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    bus.Rd = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_mem_req_rst", bus.mem_req, 16'h0000);
    check("abort_stall_rst", bus.Stall, 16'h0000);
    check("abort_done_rst", bus.Done, 16'h0000);
    check_counters();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(16'h0050, 1'b1, 1'b0, 16'h0000, 0);
    check("reread_cycles", 16'(last_k), 16'd5);
    check("reread_hit", 16'(last_hit), 16'h0000);
    access(16'h2014, 1'b1, 1'b0, 16'h0000, 1);
    check("post_rst_miss", 16'(last_hit), 16'h0000);

    for (int n = 0; n < 300; n++) begin
      tg  = tg_tab[$urandom_range(0, 3)];
      ix  = 5'($urandom_range(0, 3));
      w   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 19);
      if (sel == 0)      err_access({tg, ix, w, 1'b0}, 1'b1, 1'b1);
      else if (sel == 1) err_access({tg, ix, w, 1'b1}, 1'b0, 1'b1);
      else access({tg, ix, w, 1'b0}, sel[0], ~sel[0], 16'($urandom), $urandom_range(0, 2));
    end
    @(negedge clk);
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with its own controller. It sits directly downstream of the pipeline memory stage.
- It consumes load/store requests and produces read data, a one-cycle done pulse, and the stall that freezes the pipeline (DataMemStall).
- Misses are serviced over a single-word request/ack port to main memory.
- Tag, valid, dirty and data arrays are internal flops.

Parameters:
- INDEX_BITS, 5, number of index bits; the cache holds 2^INDEX_BITS lines.
- WORDS_PER_LINE, 4, 16-bit words per line; fixed at 4 (word offset = Addr[2:1]).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- Addr  in  16  byte address; Addr[0] must be 0
- DataIn  in  16  store data
- Rd  in  1  load request, held stable until Done
- Wr  in  1  store request, held stable until Done
- DataOut  out  16  load data, valid when Done && Rd
- Done  out  1  access complete this cycle
- Stall  out  1  pipeline stall (drives DataMemStall)
- CacheHit  out  1  access completed without memory traffic
- err  out  1  illegal request
- mem_req  out  1  memory word request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  16  word-aligned memory address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  memory completed current word (may be same cycle as mem_req)
- hit_count  out  16  see Optional Feature
- miss_count  out  16  see Optional Feature

Behaviour:
- Address split: tag = Addr[15:3+INDEX_BITS], index = Addr[2+INDEX_BITS:3], word = Addr[2:1].
- Reset (async, rst=1): state IDLE, all valid and dirty bits 0, word counter 0.
- Reset output values: Done=0, Stall=0, CacheHit=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, DataOut=0, counters 0.
- Reset mid-miss abandons the transfer; dirty data is lost.
- err is combinational, asserted when (Rd && Wr) or ((Rd || Wr) && Addr[0]). An erroring request is ignored: no state change, Done=0, Stall=0.
- IDLE:
  - Idle when no request.
  - Hit (valid && tag match): same-cycle Done=1, CacheHit=1, Stall=0.
  - Hit on Rd: DataOut = stored word.
  - Hit on Wr: word updated and dirty set at the clock edge.
  - Miss: Stall=1 combinationally. Next state is WB if the victim is valid && dirty, else ALLOC. Word counter cleared.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, counter, 1'b0}, mem_wdata = victim word[counter].
  - Each mem_ack increments the counter. On the 4th ack: counter clears, go to ALLOC.
- ALLOC:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, counter, 1'b0}.
  - Each mem_ack writes mem_rdata into line word[counter].
  - On the 4th ack: tag written, valid=1, dirty=0, go to RESPOND.
- RESPOND:
  - Access performed on the filled line exactly as a hit, except CacheHit=0. Done=1, Stall=0.
  - A store sets dirty.
  - Next state is IDLE.
- Stall is 1 in WB and ALLOC. In IDLE it is 1 only on the miss cycle. It is 0 in RESPOND.
- Done is a single-cycle pulse per request. The requester drops or changes Rd/Wr the cycle after Done. A request present in the cycle after RESPOND is a new access.
- mem_req holds until mem_ack, and mem_addr/mem_wdata stay stable while mem_req && !mem_ack.
- Request inputs are sampled only in IDLE and RESPOND. Changes during WB/ALLOC are ignored; the original Addr/DataIn must be held by the requester.
- Index aliasing: a miss to an index whose valid clean line has another tag goes straight to ALLOC.
- Line replacement uses the tag/dirty state captured at miss detection.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: hit_count increments on each IDLE hit Done; miss_count increments on each RESPOND Done. Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: no counter flops; hit_count and miss_count are tied to 0.

Test Plan:
- Cold miss: after reset, Rd Addr=16'h0010, memory acks same cycle returning 16'hA0..A3 → ALLOC reads 0x0010/12/14/16 in cycles 1-4; Done in cycle 5 with DataOut=16'hA0, CacheHit=0; Stall=1 in cycles 0-4.
- Read hit: then Rd Addr=16'h0014 → Done same cycle, DataOut=16'hA2, CacheHit=1, mem_req=0.
- Dirty eviction: Wr 16'h0012=16'hBEEF (hit, dirty), then Rd 16'h1010 (same index) → WB writes 0x0010..0x0016 with 16'hA0, 16'hBEEF, 16'hA2, 16'hA3, then ALLOC from 0x1010; Done in cycle 9.
- Ack latency: mem_ack delayed 3 cycles per word → mem_addr/mem_wdata stable while waiting; Done in cycle 17 for the clean miss.
- Errors: Rd=Wr=1, or Rd with Addr=16'h0011 → err=1, Done=0, Stall=0, no mem_req, arrays unchanged.
- Reset mid-ALLOC after the 2nd ack → state IDLE, mem_req=0; a re-read of the same address misses again. With DCACHE_STATS_EN, the counters read 0.
